// File: rtl/writeback_stage_if.sv
// Writeback stage bus: upstream instruction fields, data-memory read halves
// and the register-file write port, grouped for the writeback_stage ports.
interface writeback_stage_if #(
  parameter int DATA_W  = 32,
  parameter int HALF_W  = 16,
  parameter int RADDR_W = 4
);
  logic [DATA_W-1:0]  data_calc_i;
  logic               mem_to_reg_i;
  logic [RADDR_W-1:0] rf_wr_select_i;
  logic               rf_wr_en_i;
  logic [HALF_W-1:0]  mem_rdata_i;
  logic               mem_rvalid_i;
  logic [DATA_W-1:0]  rf_wr_data_o;
  logic [RADDR_W-1:0] rf_wr_addr_o;
  logic               rf_wr_en_o;
  logic               stall_o;
  logic               mem_err_o;

  // Upstream / memory side drives the stage.
  modport master (
    output data_calc_i, mem_to_reg_i, rf_wr_select_i, rf_wr_en_i,
           mem_rdata_i, mem_rvalid_i,
    input  rf_wr_data_o, rf_wr_addr_o, rf_wr_en_o, stall_o, mem_err_o
  );

  // The writeback stage itself.
  modport slave (
    input  data_calc_i, mem_to_reg_i, rf_wr_select_i, rf_wr_en_i,
           mem_rdata_i, mem_rvalid_i,
    output rf_wr_data_o, rf_wr_addr_o, rf_wr_en_o, stall_o, mem_err_o
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: writes ALU results or 2x16-bit assembled load data to
// the register file. Optional forwarding port enabled by `define WB_BYPASS_EN.
module writeback_stage #(
  parameter int DATA_W  = 32,
  parameter int HALF_W  = 16,
  parameter int RADDR_W = 4,
  parameter int MEM_TMO = 15
) (
  input logic             clk_i,
  input logic             rst_i,
  writeback_stage_if.slave bus
`ifdef WB_BYPASS_EN
  ,
  input  logic [RADDR_W-1:0] fwd_sel_i,
  output logic               fwd_hit_o,
  output logic [DATA_W-1:0]  fwd_data_o
`endif
);

  localparam int CNT_W = $clog2(MEM_TMO + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HALF_W-1:0]  lo_q, lo_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic [RADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               wr_en_q, wr_en_d;
  logic               err_q, err_d;
  logic               stall;
  logic               tmo;

  // Last permitted cycle without rvalid in the current wait state.
  assign tmo = (cnt_q == CNT_W'(MEM_TMO - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    dest_d  = dest_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    err_d   = err_q;
    stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rf_wr_en_i) begin
          if (bus.mem_to_reg_i) begin
            dest_d  = bus.rf_wr_select_i;
            cnt_d   = '0;
            state_d = WAIT_LO;
            stall   = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            data_d  = bus.data_calc_i;
            addr_d  = bus.rf_wr_select_i;
          end
        end
      end
      WAIT_LO: begin
        stall = 1'b1;
        if (bus.mem_rvalid_i) begin
          lo_d    = bus.mem_rdata_i;
          cnt_d   = '0;
          state_d = WAIT_HI;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (bus.mem_rvalid_i) begin
          // Releasing stall here lets upstream advance on the same edge the write issues.
          wr_en_d = 1'b1;
          data_d  = DATA_W'({bus.mem_rdata_i, lo_q});
          addr_d  = dest_q;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (tmo) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      dest_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      dest_q  <= dest_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
    end
  end

  // Gate with reset so an accepted-load request cannot hold stall high during reset.
  assign bus.stall_o      = stall & rst_i;
  assign bus.rf_wr_data_o = data_q;
  assign bus.rf_wr_addr_o = addr_q;
  assign bus.rf_wr_en_o   = wr_en_q;
  assign bus.mem_err_o    = err_q;

`ifdef WB_BYPASS_EN
  assign fwd_hit_o  = wr_en_q && (addr_q == fwd_sel_i);
  assign fwd_data_o = data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: table-driven ALU vectors plus
// hand-written load, back-to-back, timeout and reset sequences.
module tb_writeback_stage;
  localparam int DATA_W  = 32;
  localparam int HALF_W  = 16;
  localparam int RADDR_W = 4;
  localparam int MEM_TMO = 15;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  writeback_stage_if #(.DATA_W(DATA_W), .HALF_W(HALF_W), .RADDR_W(RADDR_W)) bus ();

`ifdef WB_BYPASS_EN
  logic [RADDR_W-1:0] fwd_sel_i;
  logic               fwd_hit_o;
  logic [DATA_W-1:0]  fwd_data_o;
`endif

  writeback_stage #(
    .DATA_W(DATA_W), .HALF_W(HALF_W), .RADDR_W(RADDR_W), .MEM_TMO(MEM_TMO)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef WB_BYPASS_EN
    ,
    .fwd_sel_i  (fwd_sel_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_data_o (fwd_data_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Every register-file write observed, sampled on the falling edge.
  logic [DATA_W-1:0]  wq_data[$];
  logic [RADDR_W-1:0] wq_addr[$];
  always @(negedge clk_i) begin
    if (bus.rf_wr_en_o === 1'b1) begin
      wq_data.push_back(bus.rf_wr_data_o);
      wq_addr.push_back(bus.rf_wr_addr_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rf_wr_en_i     = 1'b0;
    bus.mem_to_reg_i   = 1'b0;
    bus.rf_wr_select_i = '0;
    bus.data_calc_i    = '0;
    bus.mem_rvalid_i   = 1'b0;
    bus.mem_rdata_i    = '0;
  endtask

  // Present a load and hold it until stall drops; returns just after the write edge.
  task automatic load_seq(input string tag, input logic [3:0] sel, input logic [15:0] lo,
                          input logic [15:0] hi, input int lo_wait, input int hi_wait);
    bus.rf_wr_en_i     = 1'b1;
    bus.mem_to_reg_i   = 1'b1;
    bus.rf_wr_select_i = sel;
    bus.data_calc_i    = 32'hFFFF_0000;
    #1 check({tag, " accept stall"}, 32'(bus.stall_o), 32'd1);
    step();
    for (int i = 0; i < lo_wait; i++) step();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = lo;
    #1 check({tag, " lo stall"}, 32'(bus.stall_o), 32'd1);
    step();
    bus.mem_rvalid_i = 1'b0;
    for (int i = 0; i < hi_wait; i++) begin
      #1 check({tag, " hi wait stall"}, 32'(bus.stall_o), 32'd1);
      step();
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = hi;
    #1 check({tag, " hi stall drop"}, 32'(bus.stall_o), 32'd0);
    step();
    idle_inputs();
  endtask

  typedef struct {
    logic        wr_en;
    logic        m2r;
    logic [3:0]  sel;
    logic [31:0] calc;
    logic        exp_en;
    logic [31:0] exp_data;
    logic [3:0]  exp_addr;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[6];
  int   n0;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'h3, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'h3, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 4'h7, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 4'h3, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'h0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'h9, 32'h0000_AAAA, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'hA, 32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A, 4'hA, 1'b0};

    idle_inputs();
`ifdef WB_BYPASS_EN
    fwd_sel_i = '0;
`endif
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    check("reset wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    check("reset data",  bus.rf_wr_data_o, 32'd0);
    check("reset addr",  32'(bus.rf_wr_addr_o), 32'd0);
    check("reset stall", 32'(bus.stall_o), 32'd0);
    check("reset err",   32'(bus.mem_err_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    step();

    // ALU-path vectors, including ignored instructions with wr_en low.
    for (int i = 0; i < 6; i++) begin
      bus.rf_wr_en_i     = vecs[i].wr_en;
      bus.mem_to_reg_i   = vecs[i].m2r;
      bus.rf_wr_select_i = vecs[i].sel;
      bus.data_calc_i    = vecs[i].calc;
      #1 check($sformatf("v%0d stall", i), 32'(bus.stall_o), 32'(vecs[i].exp_stall));
      step();
      check($sformatf("v%0d wr_en", i), 32'(bus.rf_wr_en_o), 32'(vecs[i].exp_en));
      check($sformatf("v%0d data", i), bus.rf_wr_data_o, vecs[i].exp_data);
      check($sformatf("v%0d addr", i), 32'(bus.rf_wr_addr_o), 32'(vecs[i].exp_addr));
`ifdef WB_BYPASS_EN
      if (i == 0) begin
        fwd_sel_i = 4'h3;
        #1 check("fwd hit sel3", 32'(fwd_hit_o), 32'd1);
        check("fwd data sel3", fwd_data_o, 32'h1234_5678);
        fwd_sel_i = 4'h4;
        #1 check("fwd hit sel4", 32'(fwd_hit_o), 32'd0);
      end
`endif
      idle_inputs();
      step();
      check($sformatf("v%0d pulse end", i), 32'(bus.rf_wr_en_o), 32'd0);
    end

    // Single load: lo, one empty cycle, hi.
    n0 = wq_data.size();
    load_seq("load", 4'h5, 16'hBEEF, 16'hDEAD, 0, 1);
    check("load wr_en", 32'(bus.rf_wr_en_o), 32'd1);
    check("load data",  bus.rf_wr_data_o, 32'hDEAD_BEEF);
    check("load addr",  32'(bus.rf_wr_addr_o), 32'd5);
    step();
    check("load pulse end", 32'(bus.rf_wr_en_o), 32'd0);
    check("load write count", 32'(wq_data.size() - n0), 32'd1);

    // Load followed immediately by an ALU op that was waiting on stall.
    n0 = wq_data.size();
    load_seq("b2b", 4'h6, 16'h1111, 16'h2222, 0, 0);
    bus.rf_wr_en_i     = 1'b1;
    bus.rf_wr_select_i = 4'h2;
    bus.data_calc_i    = 32'hCAFE_F00D;
    step();
    idle_inputs();
    step();
    check("b2b write count", 32'(wq_data.size() - n0), 32'd2);
    if (wq_data.size() - n0 == 2) begin
      check("b2b first data",  wq_data[n0], 32'h2222_1111);
      check("b2b first addr",  32'(wq_addr[n0]), 32'd6);
      check("b2b second data", wq_data[n0+1], 32'hCAFE_F00D);
      check("b2b second addr", 32'(wq_addr[n0+1]), 32'd2);
    end

    // Long waits in both halves: the counter restarts on entry to WAIT_HI.
    load_seq("slow", 4'h9, 16'h0101, 16'h0202, 10, 10);
    check("slow data", bus.rf_wr_data_o, 32'h0202_0101);
    check("slow err",  32'(bus.mem_err_o), 32'd0);
    step();

    // Timeout: no rvalid after acceptance.
    n0 = wq_data.size();
    bus.rf_wr_en_i     = 1'b1;
    bus.mem_to_reg_i   = 1'b1;
    bus.rf_wr_select_i = 4'h8;
    step();
    idle_inputs();
    repeat (MEM_TMO - 1) step();
    check("tmo err before", 32'(bus.mem_err_o), 32'd0);
    check("tmo stall before", 32'(bus.stall_o), 32'd1);
    step();
    check("tmo err", 32'(bus.mem_err_o), 32'd1);
    check("tmo stall", 32'(bus.stall_o), 32'd0);
    check("tmo no write", 32'(wq_data.size() - n0), 32'd0);
    bus.rf_wr_en_i     = 1'b1;
    bus.rf_wr_select_i = 4'h1;
    bus.data_calc_i    = 32'h0000_0005;
    step();
    idle_inputs();
    check("post-tmo wr_en", 32'(bus.rf_wr_en_o), 32'd1);
    check("post-tmo data",  bus.rf_wr_data_o, 32'h0000_0005);
    check("err sticky",     32'(bus.mem_err_o), 32'd1);
    step();

    // Reset while waiting for the hi half.
    n0 = wq_data.size();
    bus.rf_wr_en_i     = 1'b1;
    bus.mem_to_reg_i   = 1'b1;
    bus.rf_wr_select_i = 4'hC;
    step();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 16'h3333;
    step();
    idle_inputs();
    #2 rst_i = 1'b0;
    #1;
    check("rst stall", 32'(bus.stall_o), 32'd0);
    check("rst data",  bus.rf_wr_data_o, 32'd0);
    check("rst addr",  32'(bus.rf_wr_addr_o), 32'd0);
    check("rst err",   32'(bus.mem_err_o), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 16'h4444;
    step();
    check("rst rvalid ignored", 32'(bus.rf_wr_en_o), 32'd0);
    bus.mem_rvalid_i   = 1'b0;
    bus.rf_wr_en_i     = 1'b1;
    bus.rf_wr_select_i = 4'h4;
    bus.data_calc_i    = 32'h0BAD_F00D;
    step();
    idle_inputs();
    check("after rst wr_en", 32'(bus.rf_wr_en_o), 32'd1);
    check("after rst data",  bus.rf_wr_data_o, 32'h0BAD_F00D);
    check("after rst addr",  32'(bus.rf_wr_addr_o), 32'd4);
    step();
    check("rst write count", 32'(wq_data.size() - n0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
